status_flag_reg: RTL and testbench

STATUS_FLAG_REG -- requirements
Module: status_flag_reg

---
 rtl/status_flag_reg_if.sv | 16 +
 rtl/status_flag_reg.sv | 103 ++++++++++
 tb/tb_status_flag_reg.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/status_flag_reg_if.sv
// Register-bus signals for status_flag_reg: a single transfer strobe (xfc)
// qualifies address/wdata/we, and read data returns with a one-cycle rvalid.
interface status_flag_reg_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              xfc;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output address, wdata, we, xfc, input rdata, rvalid);
    modport slave  (input address, wdata, we, xfc, output rdata, rvalid);
endinterface

// File: rtl/status_flag_reg.sv
// Sticky event status register with W1C flags, interrupt enables and
// saturating per-event counters, accessed over a simple transfer bus.
module status_flag_reg (
    input  logic             clk,
    input  logic             rst,
    status_flag_reg_if.slave bus,
    input  logic             ev_i2si_overrun,
    input  logic             ev_i2so_underrun,
    input  logic             ev_filter_ovf,
    output logic             irq
);
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_EV = 3;

    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 11'h008;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 11'h009;
    localparam logic [ADDR_W-1:0] ADDR_CNT_OVR  = 11'h00A;
    localparam logic [ADDR_W-1:0] ADDR_CNT_UND  = 11'h00B;
    localparam logic [ADDR_W-1:0] ADDR_CNT_FOVF = 11'h00C;

    // Event i lives at STATUS/IRQ_EN bit 2*i
    localparam logic [DATA_W-1:0] FLAG_MASK = 8'h15;
    localparam logic [DATA_W-1:0] CNT_MAX   = 8'hFF;

    logic [NUM_EV-1:0] ev;
    logic [NUM_EV-1:0] ev_prev;
    logic [NUM_EV-1:0] ev_rise_c;
    logic [NUM_EV-1:0] cnt_wr_c;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] irq_en;
    logic [DATA_W-1:0] status_nxt_c;
    logic [DATA_W-1:0] irq_en_nxt_c;
    logic [DATA_W-1:0] set_c;
    logic [DATA_W-1:0] w1c_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic [DATA_W-1:0] cnt     [NUM_EV];
    logic [DATA_W-1:0] cnt_nxt_c [NUM_EV];
    logic              wr_c;
    logic              rd_c;

    assign ev = {ev_filter_ovf, ev_i2so_underrun, ev_i2si_overrun};

    // Next-state for flags, enables and counters; set and count beat a same-cycle clear
    always_comb begin
        wr_c         = bus.xfc & bus.we;
        rd_c         = bus.xfc & ~bus.we;
        ev_rise_c    = ev & ~ev_prev;
        set_c        = {3'b000, ev_rise_c[2], 1'b0, ev_rise_c[1], 1'b0, ev_rise_c[0]};
        w1c_c        = '0;
        irq_en_nxt_c = irq_en;
        cnt_wr_c     = '0;

        if (wr_c) begin
            if (bus.address == ADDR_STATUS) w1c_c = bus.wdata;
            if (bus.address == ADDR_IRQ_EN) irq_en_nxt_c = bus.wdata & FLAG_MASK;
            cnt_wr_c[0] = (bus.address == ADDR_CNT_OVR);
            cnt_wr_c[1] = (bus.address == ADDR_CNT_UND);
            cnt_wr_c[2] = (bus.address == ADDR_CNT_FOVF);
        end

        status_nxt_c = ((status & ~w1c_c) | set_c) & FLAG_MASK;

        for (int i = 0; i < NUM_EV; i++) begin
            cnt_nxt_c[i] = cnt_wr_c[i] ? '0 : cnt[i];
            if (ev_rise_c[i] && (cnt_nxt_c[i] != CNT_MAX))
                cnt_nxt_c[i] = cnt_nxt_c[i] + DATA_W'(1);
        end
    end

    // Read data reflects register state before this cycle's update
    always_comb begin
        rd_mux_c = '0;
        case (bus.address)
            ADDR_STATUS:   rd_mux_c = status;
            ADDR_IRQ_EN:   rd_mux_c = irq_en;
            ADDR_CNT_OVR:  rd_mux_c = cnt[0];
            ADDR_CNT_UND:  rd_mux_c = cnt[1];
            ADDR_CNT_FOVF: rd_mux_c = cnt[2];
            default:       rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_prev    <= '0;
            status     <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            for (int i = 0; i < NUM_EV; i++) cnt[i] <= '0;
        end else begin
            ev_prev    <= ev;
            status     <= status_nxt_c;
            irq_en     <= irq_en_nxt_c;
            irq        <= |(status & irq_en);
            bus.rvalid <= rd_c;
            if (rd_c) bus.rdata <= rd_mux_c;
            for (int i = 0; i < NUM_EV; i++) cnt[i] <= cnt_nxt_c[i];
        end
    end
endmodule

// File: tb/tb_status_flag_reg.sv
// Directed bench for status_flag_reg: a per-cycle reference model of the
// register map plus hand-computed read expectations.
module tb_status_flag_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ev_ovr = 1'b0;
    logic ev_und = 1'b0;
    logic ev_fovf = 1'b0;
    logic irq;

    status_flag_reg_if bus ();

    status_flag_reg dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .ev_i2si_overrun  (ev_ovr),
        .ev_i2so_underrun (ev_und),
        .ev_filter_ovf    (ev_fovf),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one flag/enable/counter per event, counters as plain ints
    bit       m_flag [3];
    bit       m_en   [3];
    int       m_cnt  [3];
    bit       m_prev [3];
    bit       m_evs  [3];
    bit [7:0] m_rdata  = 8'h00;
    bit       m_rvalid = 1'b0;
    bit       m_irq    = 1'b0;
    bit       chk_en   = 1'b0;
    bit       m_any;

    function automatic bit [7:0] model_read(input logic [10:0] a);
        bit [7:0] v;
        v = 8'h00;
        if (a == 11'h008) begin
            for (int i = 0; i < 3; i++) if (m_flag[i]) v = v | (8'h01 << (2 * i));
        end else if (a == 11'h009) begin
            for (int i = 0; i < 3; i++) if (m_en[i]) v = v | (8'h01 << (2 * i));
        end else if (a >= 11'h00A && a <= 11'h00C) begin
            v = 8'(m_cnt[a - 11'h00A]);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        m_evs[0] = ev_ovr;
        m_evs[1] = ev_und;
        m_evs[2] = ev_fovf;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_flag[i] = 0; m_en[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
            end
            m_rdata  = 8'h00;
            m_rvalid = 0;
            m_irq    = 0;
            chk_en   = 1;
        end else begin
            m_rvalid = bus.xfc && !bus.we;
            if (m_rvalid) m_rdata = model_read(bus.address);
            m_any = 0;
            for (int i = 0; i < 3; i++) if (m_flag[i] && m_en[i]) m_any = 1;
            m_irq = m_any;
            if (bus.xfc && bus.we) begin
                for (int i = 0; i < 3; i++) begin
                    if (bus.address == 11'h008 && bus.wdata[2*i]) m_flag[i] = 0;
                    if (bus.address == 11'h009) m_en[i] = bus.wdata[2*i];
                    if (bus.address == 11'(11'h00A + i)) m_cnt[i] = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (m_evs[i] && !m_prev[i]) begin
                    m_flag[i] = 1;
                    m_cnt[i]  = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
                end
                m_prev[i] = m_evs[i];
            end
        end
    end

    // Every-cycle comparison of the DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.rvalid !== m_rvalid) begin
                errors++;
                $display("FAIL model_rvalid t=%0t got %b want %b", $time, bus.rvalid, m_rvalid);
            end
            checks++;
            if (bus.rdata !== m_rdata) begin
                errors++;
                $display("FAIL model_rdata t=%0t got %02h want %02h", $time, bus.rdata, m_rdata);
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL model_irq t=%0t got %b want %b", $time, irq, m_irq);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h want %02h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [7:0] d);
        bus.address = a; bus.wdata = d; bus.we = 1'b1; bus.xfc = 1'b1;
        step(1);
        bus.xfc = 1'b0; bus.we = 1'b0; bus.wdata = 8'h5A;
    endtask

    task automatic bus_read(input string name, input logic [10:0] a, input logic [7:0] want);
        bus.address = a; bus.we = 1'b0; bus.xfc = 1'b1;
        step(1);
        bus.xfc = 1'b0;
        check({name, "_rvalid"}, 8'(bus.rvalid), 8'h01);
        check(name, bus.rdata, want);
    endtask

    initial begin
        bus.address = '0; bus.wdata = '0; bus.we = 1'b0; bus.xfc = 1'b0;
        step(3);
        rst = 1'b0;
        check("reset_rvalid", 8'(bus.rvalid), 8'h00);
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_irq", 8'(irq), 8'h00);

        // Single overrun edge, then held high: counted once
        ev_ovr = 1'b1;
        step(1);
        bus_read("status_ovr", 11'h008, 8'h01);
        bus_read("cnt_ovr", 11'h00A, 8'h01);
        step(10);
        bus_read("cnt_ovr_held", 11'h00A, 8'h01);
        ev_ovr = 1'b0;

        // W1C behaviour
        ev_und = 1'b1; ev_fovf = 1'b1;
        step(1);
        ev_und = 1'b0; ev_fovf = 1'b0;
        bus_read("status_all", 11'h008, 8'h15);
        bus_write(11'h008, 8'h04);
        bus_read("status_w1c", 11'h008, 8'h11);
        bus_write(11'h008, 8'h00);
        bus_read("status_w0", 11'h008, 8'h11);
        bus_read("read_no_clear", 11'h008, 8'h11);

        // Set beats same-cycle W1C; count beats same-cycle counter clear
        ev_fovf = 1'b1;
        bus_write(11'h008, 8'h10);
        ev_fovf = 1'b0;
        bus_read("status_collide", 11'h008, 8'h11);
        bus_read("cnt_fovf_2", 11'h00C, 8'h02);
        ev_fovf = 1'b1;
        bus_write(11'h00C, 8'hAA);
        ev_fovf = 1'b0;
        bus_read("cnt_fovf_collide", 11'h00C, 8'h01);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            ev_und = 1'b1; step(1);
            ev_und = 1'b0; step(1);
        end
        bus_read("cnt_und_sat", 11'h00B, 8'hFF);
        bus_write(11'h00B, 8'h00);
        bus_read("cnt_und_clr", 11'h00B, 8'h00);

        // Enable masking and irq timing
        bus_write(11'h008, 8'h15);
        bus_write(11'h009, 8'hFF);
        bus_read("irq_en_mask", 11'h009, 8'h15);
        bus_write(11'h009, 8'h04);
        bus_read("irq_en", 11'h009, 8'h04);
        check("irq_idle", 8'(irq), 8'h00);
        ev_und = 1'b1;
        step(1);
        ev_und = 1'b0;
        check("irq_edge_plus1", 8'(irq), 8'h00);
        step(1);
        check("irq_edge_plus2", 8'(irq), 8'h01);
        bus_write(11'h008, 8'h04);
        check("irq_w1c_plus0", 8'(irq), 8'h01);
        step(1);
        check("irq_w1c_plus1", 8'(irq), 8'h00);
        ev_ovr = 1'b1;
        step(3);
        ev_ovr = 1'b0;
        check("irq_masked", 8'(irq), 8'h00);

        // Unmapped accesses
        bus_read("unmapped_rd", 11'h00D, 8'h00);
        bus_write(11'h00D, 8'hFF);
        bus_write(11'h7FF, 8'hFF);
        bus_read("unmapped_no_fx", 11'h008, 8'h01);
        bus_read("unmapped_rd_hi", 11'h408, 8'h00);

        // Reset during a read, with irq active
        ev_und = 1'b1; step(1); ev_und = 1'b0;
        step(2);
        check("irq_before_rst", 8'(irq), 8'h01);
        bus.address = 11'h00A; bus.we = 1'b0; bus.xfc = 1'b1;
        step(1);
        bus.xfc = 1'b0;
        check("pre_rst_rvalid", 8'(bus.rvalid), 8'h01);
        rst = 1'b1;
        step(1);
        check("rst_rvalid", 8'(bus.rvalid), 8'h00);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_irq", 8'(irq), 8'h00);
        ev_ovr = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        bus_read("post_rst_status", 11'h008, 8'h01);
        bus_read("post_rst_cnt_ovr", 11'h00A, 8'h01);
        bus_read("post_rst_cnt_und", 11'h00B, 8'h00);
        bus_read("post_rst_irq_en", 11'h009, 8'h00);
        ev_ovr = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
